latch_write_sequencer: RTL

- Writer-side controller for a bank of level-sensitive register latches (NrOfBits wide, NrOfLatches deep).
- Accepts write or clear requests over a valid/ready handshake.
- Drives each transaction to the latches in three phases: data setup, transparent gate window, then data hold.
- Guarantees the latch gate is never open while its data input changes. Sits between the CPU/display-control logic and the latch bank.

---
 rtl/latch_write_sequencer_pkg.sv | 25 ++
 rtl/latch_phase_counter.sv | 29 ++
 rtl/latch_write_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/latch_write_sequencer_pkg.sv
// Shared definitions for the latch write sequencer: FSM encoding and width helpers.
package latch_write_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_GATE  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Index width for n entries, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width needed to hold a down-count that starts at n-1.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_phase_counter.sv
// Loadable down-counter shared by the setup, gate and hold phases.
// Latency: load and advance take effect at the next edge; terminal flags a count of zero.
module latch_phase_counter #(
    parameter int Width = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             advance,
    output logic             terminal
);

    logic [Width-1:0] count;

    assign terminal = (count == '0);

    // Load wins over advance so a phase change restarts cleanly on a ticking edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (advance && !terminal) begin
            count <= count - Width'(1);
        end
    end

endmodule

// File: rtl/latch_write_sequencer.sv
// Writer-side sequencer for a level-sensitive latch bank: setup, gate window, hold.
// Latency: done pulses SetupCycles+GateCycles+HoldCycles+1 cycles after accept; wr_ready low while busy.
module latch_write_sequencer
    import latch_write_sequencer_pkg::*;
#(
    parameter int NrOfBits    = 8,
    parameter int NrOfLatches = 4,
    parameter bit ActiveLevel = 1'b1,
    parameter int SetupCycles = 1,
    parameter int GateCycles  = 2,
    parameter int HoldCycles  = 1,
    localparam int AW         = addr_width(NrOfLatches)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ClockEnable,
    input  logic                   Tick,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_clear,
    input  logic [AW-1:0]          wr_addr,
    input  logic [NrOfBits-1:0]    wr_data,
    output logic [NrOfBits-1:0]    lat_d,
    output logic [NrOfLatches-1:0] lat_gate,
    output logic [NrOfLatches-1:0] lat_clr,
    output logic                   lat_tick,
    output logic                   busy,
    output logic                   done,
    output logic                   addr_err
);

    localparam int CW = count_width(max3(SetupCycles, GateCycles, HoldCycles));
    localparam logic [AW:0]          NL        = (AW + 1)'(NrOfLatches);
    localparam logic [NrOfLatches-1:0] GATE_OFF = {NrOfLatches{~ActiveLevel}};

    if (SetupCycles < 1) begin : g_bad_setup
        $error("SetupCycles must be at least 1");
    end
    if (GateCycles < 1) begin : g_bad_gate
        $error("GateCycles must be at least 1");
    end
    if (HoldCycles < 1) begin : g_bad_hold
        $error("HoldCycles must be at least 1");
    end

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   rdy_q;
    logic [AW-1:0]          addr_q;
    logic                   clear_q;
    logic                   addr_ok_q;
    logic                   advance;
    logic                   accept;
    logic                   cnt_load;
    logic [CW-1:0]          cnt_val;
    logic                   cnt_tc;
    logic                   finishing;
    logic [NrOfLatches-1:0] sel;

    assign advance  = ClockEnable & Tick;
    assign wr_ready = rdy_q & ClockEnable;
    assign accept   = wr_valid & wr_ready;

    latch_phase_counter #(
        .Width(CW)
    ) u_phase_cnt (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .advance  (advance),
        .terminal (cnt_tc)
    );

    // Each phase preloads length-1 so terminal is reached on its last advancing cycle.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(SetupCycles - 1);
                end
            end
            ST_SETUP: begin
                if (advance && cnt_tc) begin
                    state_d  = ST_GATE;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(GateCycles - 1);
                end
            end
            ST_GATE: begin
                if (advance && cnt_tc) begin
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(HoldCycles - 1);
                end
            end
            default: begin
                if (advance && cnt_tc) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign finishing = (state_q == ST_HOLD) && (state_d == ST_IDLE);

    // Out-of-range indices decode to no select bit at all.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NrOfLatches; i++) begin
            if (addr_q == AW'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b0;
            addr_q    <= '0;
            clear_q   <= 1'b0;
            addr_ok_q <= 1'b0;
            lat_d     <= '0;
            lat_gate  <= GATE_OFF;
            lat_clr   <= '0;
            lat_tick  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= (state_d == ST_IDLE);
            busy     <= (state_d != ST_IDLE);
            done     <= finishing;
            addr_err <= finishing & ~addr_ok_q;
            lat_tick <= (state_d == ST_GATE);

            if (accept) begin
                addr_q    <= wr_addr;
                clear_q   <= wr_clear;
                addr_ok_q <= ({1'b0, wr_addr} < NL);
                lat_d     <= wr_clear ? '0 : wr_data;
            end

            // lat_d only moves on accept, which is never during GATE, so the gate sees stable data.
            if ((state_d == ST_GATE) && !clear_q) begin
                lat_gate <= sel ^ GATE_OFF;
            end else begin
                lat_gate <= GATE_OFF;
            end

            if ((state_d == ST_GATE) && clear_q) begin
                lat_clr <= sel;
            end else begin
                lat_clr <= '0;
            end
        end
    end

endmodule
